// File: rtl/df_prof_pkg.sv
// rtl/df_prof_pkg.sv - shared types and saturating increment for the dataflow stall profiler
package df_prof_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE_WAIT = 2'd2
  } proc_state_t;

  typedef enum logic [1:0] {
    SEL_ACTIVE = 2'd0,
    SEL_CIN    = 2'd1,
    SEL_COUT   = 2'd2,
    SEL_RUNS   = 2'd3
  } rd_sel_t;

  localparam int unsigned MAX_CNT_W = 64;

  // Callers zero-extend their counter and truncate the result back to their own width.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                   input int unsigned width);
    logic [MAX_CNT_W-1:0] top;
    top = (width >= MAX_CNT_W) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= top) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/df_proc_tracker.sv
// rtl/df_proc_tracker.sv - per-process ap handshake FSM with active/stall/run counters
module df_proc_tracker
  import df_prof_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             start,
  input  logic             done,
  input  logic             cont,
  input  logic             cin_stall,
  input  logic             cout_stall,
  output logic [1:0]       state,
  output logic             stalled,
  output logic [CNT_W-1:0] active_cnt,
  output logic [CNT_W-1:0] cin_cnt,
  output logic [CNT_W-1:0] cout_cnt,
  output logic [CNT_W-1:0] runs_cnt
);

  proc_state_t cur, nxt;
  logic        in_run;
  logic        run_done;

  always_ff @(posedge clock) begin
    if (!reset) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:      if (start) nxt = RUN;
      RUN:       if (done) begin
                   if (!cont)     nxt = DONE_WAIT;
                   else if (start) nxt = RUN;
                   else            nxt = IDLE;
                 end
      DONE_WAIT: if (cont) nxt = start ? RUN : IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    in_run   = (cur == RUN);
    run_done = ((cur == RUN) || (cur == DONE_WAIT)) && done && cont;
    stalled  = cin_stall | cout_stall;
    state    = cur;
  end

  // Input stall wins, so a cycle never lands in both stall counters.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      active_cnt <= '0;
      cin_cnt    <= '0;
      cout_cnt   <= '0;
      runs_cnt   <= '0;
    end else if (enable) begin
      if (in_run)
        active_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(active_cnt), CNT_W));
      if (in_run && cin_stall)
        cin_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(cin_cnt), CNT_W));
      if (in_run && cout_stall && !cin_stall)
        cout_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(cout_cnt), CNT_W));
      if (run_done)
        runs_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(runs_cnt), CNT_W));
    end
  end

endmodule

// File: rtl/df_stall_profiler.sv
// rtl/df_stall_profiler.sv - dataflow region profiler: trackers, region counters, deadlock detect, read port
module df_stall_profiler
  import df_prof_pkg::*;
#(
  parameter int NUM_PROC = 4,
  parameter int CNT_W    = 32,
  parameter int DL_TH    = 1024,
  parameter int PIDX_W   = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                top_start,
  input  logic                top_ready,
  input  logic                top_done,
  input  logic [NUM_PROC-1:0] proc_start,
  input  logic [NUM_PROC-1:0] proc_ready,
  input  logic [NUM_PROC-1:0] proc_done,
  input  logic [NUM_PROC-1:0] proc_continue,
  input  logic [NUM_PROC-1:0] proc_cin_stall,
  input  logic [NUM_PROC-1:0] proc_cout_stall,
  output logic                region_idle,
  output logic [CNT_W-1:0]    region_start_cnt,
  output logic [CNT_W-1:0]    region_done_cnt,
  output logic                deadlock,
  output logic [NUM_PROC-1:0] deadlock_mask,
  input  logic                rd_req,
  input  logic [PIDX_W-1:0]   rd_proc,
  input  logic [1:0]          rd_sel,
  output logic                rd_valid,
  output logic [CNT_W-1:0]    rd_data
);

  localparam int DL_W = $clog2(DL_TH);

  logic [1:0]          st       [NUM_PROC];
  logic [CNT_W-1:0]    act_c    [NUM_PROC];
  logic [CNT_W-1:0]    cin_c    [NUM_PROC];
  logic [CNT_W-1:0]    cout_c   [NUM_PROC];
  logic [CNT_W-1:0]    runs_c   [NUM_PROC];
  logic [NUM_PROC-1:0] run_vec;
  logic [NUM_PROC-1:0] stalled_vec;
  logic                stuck;
  logic [DL_W-1:0]     dl_cnt;
  logic [CNT_W-1:0]    sel_val;
  logic                unused_ready;

  assign unused_ready = ^proc_ready;

  for (genvar g = 0; g < NUM_PROC; g++) begin : g_proc
    df_proc_tracker #(.CNT_W(CNT_W)) u_trk (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .clear      (clear),
      .start      (proc_start[g]),
      .done       (proc_done[g]),
      .cont       (proc_continue[g]),
      .cin_stall  (proc_cin_stall[g]),
      .cout_stall (proc_cout_stall[g]),
      .state      (st[g]),
      .stalled    (stalled_vec[g]),
      .active_cnt (act_c[g]),
      .cin_cnt    (cin_c[g]),
      .cout_cnt   (cout_c[g]),
      .runs_cnt   (runs_c[g])
    );
    assign run_vec[g] = (st[g] == RUN);
  end

  assign region_idle = (region_start_cnt == region_done_cnt) && !top_start;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      region_start_cnt <= '0;
      region_done_cnt  <= '0;
    end else if (enable) begin
      if (top_start && top_ready)
        region_start_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(region_start_cnt), CNT_W));
      if (top_done)
        region_done_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(region_done_cnt), CNT_W));
    end
  end

  // Any done means the graph is still making progress, even if every runner looks stalled.
  assign stuck = (|run_vec) && ((run_vec & ~stalled_vec) == '0) && !(|proc_done);

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      dl_cnt        <= '0;
      deadlock      <= 1'b0;
      deadlock_mask <= '0;
    end else if (stuck) begin
      if (dl_cnt == DL_W'(DL_TH - 1)) begin
        if (!deadlock) begin
          deadlock      <= 1'b1;
          deadlock_mask <= run_vec & stalled_vec;
        end
      end else begin
        dl_cnt <= dl_cnt + DL_W'(1);
      end
    end else begin
      dl_cnt <= '0;
    end
  end

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (rd_proc == PIDX_W'(i)) begin
        case (rd_sel_t'(rd_sel))
          SEL_ACTIVE: sel_val = act_c[i];
          SEL_CIN:    sel_val = cin_c[i];
          SEL_COUT:   sel_val = cout_c[i];
          default:    sel_val = runs_c[i];
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= sel_val;
    end
  end

endmodule
